weight_cache_pingpong: RTL

WEIGHT_CACHE_PINGPONG -- requirements
Module: weight_cache_pingpong

---
 rtl/wc_pkg.sv | 11 +
 rtl/wc_bank_ram.sv | 25 ++
 rtl/weight_cache_pingpong.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/wc_pkg.sv
// wc_pkg: shared types and default sizing for the ping-pong weight cache.
//   fill_state_t  : fill-side FSM states (idle / loading / full, awaiting swap)
//   drain_state_t : drain-side FSM states (idle / replaying)
package wc_pkg;
  localparam int WC_DATA_W = 64;
  localparam int WC_DEPTH  = 4096;
  localparam int WC_CNT_W  = 20;

  typedef enum logic [1:0] {F_IDLE, F_LOAD, F_FULL} fill_state_t;
  typedef enum logic       {D_IDLE, D_RUN}          drain_state_t;
endpackage

// File: rtl/wc_bank_ram.sv
// wc_bank_ram: simple dual-port buffer bank, one write port, one read port,
// registered (1-cycle) read. Contents are not reset.
//   clk         : clock
//   we/waddr/wdata : write port
//   re/raddr    : read request; rdata valid the cycle after re
module wc_bank_ram #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4096,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/weight_cache_pingpong.sv
// weight_cache_pingpong: two-bank weight cache. One bank is filled from the
// s_* stream while the other is replayed cfg_passes times to the consumer.
//   clk, rst_n            : clock, async active-low reset
//   start, cfg_*          : layer config; latched on an accepted start
//   s_valid/s_ready/s_data: weight word input
//   raddr_valid           : consumer read request (drain side)
//   w_valid/w_data/w_last : read data, one cycle after the request
//   weight_cached         : drain bank holds a complete layer
//   layer_end             : abort drain and release the bank
//   busy, err_cfg         : activity flag, sticky config error
module weight_cache_pingpong
  import wc_pkg::*;
#(
  parameter int DATA_W = WC_DATA_W,
  parameter int DEPTH  = WC_DEPTH,
  parameter int CNT_W  = WC_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       cfg_rows,
  input  logic [15:0]       cfg_cols,
  input  logic [CNT_W-1:0]  cfg_passes,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              raddr_valid,
  output logic              w_valid,
  output logic [DATA_W-1:0] w_data,
  output logic              w_last,
  output logic              weight_cached,
  input  logic              layer_end,
  output logic              busy,
  output logic              err_cfg
);
  localparam int LANES = DATA_W / 8;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fill_state_t  fstate;
  drain_state_t dstate;

  logic             fill_sel;   // bank being filled; drain bank is ~fill_sel
  logic [CNT_W-1:0] fill_words, fill_passes, drain_words, drain_passes;
  logic [CNT_W-1:0] wr_cnt, rd_addr, pass_cnt;
  logic             rd_vld, rd_last, rd_fin, rd_bank;
  logic [1:0][DATA_W-1:0] bank_q;

  // words per layer = rows * ceil(cols / LANES)
  logic [31:0] col_words, cfg_words;
  logic        cfg_bad;
  assign col_words = ({16'd0, cfg_cols} + 32'(LANES - 1)) / 32'(LANES);
  assign cfg_words = {16'd0, cfg_rows} * col_words;
  assign cfg_bad   = (cfg_rows == '0) || (cfg_cols == '0) || (cfg_passes == '0) ||
                     (cfg_words > 32'(DEPTH));

  logic accept, rd_issue, rd_wrap, swap;
  assign s_ready  = (fstate == F_LOAD);
  assign accept   = s_valid && s_ready;
  // layer_end wins over a same-cycle read request
  assign rd_issue = (dstate == D_RUN) && raddr_valid && !layer_end;
  assign rd_wrap  = (rd_addr == drain_words - 1'b1);
  assign swap     = (fstate == F_FULL) && (dstate == D_IDLE);

  // ---------------- fill side ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fstate      <= F_IDLE;
      wr_cnt      <= '0;
      fill_words  <= '0;
      fill_passes <= '0;
      err_cfg     <= 1'b0;
    end else begin
      case (fstate)
        F_IDLE: if (start) begin
          if (cfg_bad) err_cfg <= 1'b1;
          else begin
            fill_words  <= CNT_W'(cfg_words);
            fill_passes <= cfg_passes;
            wr_cnt      <= '0;
            fstate      <= F_LOAD;
          end
        end
        F_LOAD: if (accept) begin
          if (wr_cnt == fill_words - 1'b1) begin
            wr_cnt <= '0;
            fstate <= F_FULL;
          end else wr_cnt <= wr_cnt + 1'b1;
        end
        F_FULL: if (swap) fstate <= F_IDLE;
        default: fstate <= F_IDLE;
      endcase
    end
  end

  // ---------------- drain side ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dstate        <= D_IDLE;
      fill_sel      <= 1'b0;
      drain_words   <= '0;
      drain_passes  <= '0;
      rd_addr       <= '0;
      pass_cnt      <= '0;
      weight_cached <= 1'b0;
      rd_vld        <= 1'b0;
      rd_last       <= 1'b0;
      rd_fin        <= 1'b0;
      rd_bank       <= 1'b0;
    end else begin
      rd_vld  <= rd_issue;
      rd_last <= rd_issue && rd_wrap;
      rd_fin  <= rd_issue && rd_wrap && (pass_cnt == drain_passes - 1'b1);
      if (rd_issue) rd_bank <= ~fill_sel;

      // cached flag drops the cycle after the final word is presented
      if (rd_vld && rd_fin) weight_cached <= 1'b0;
      if (layer_end)        weight_cached <= 1'b0;

      if (dstate == D_IDLE) begin
        if (swap) begin
          // bank and its latched config change roles together
          fill_sel      <= ~fill_sel;
          drain_words   <= fill_words;
          drain_passes  <= fill_passes;
          rd_addr       <= '0;
          pass_cnt      <= '0;
          dstate        <= D_RUN;
          weight_cached <= 1'b1;
        end
      end else if (layer_end) begin
        dstate   <= D_IDLE;
        rd_addr  <= '0;
        pass_cnt <= '0;
      end else if (rd_issue) begin
        if (rd_wrap) begin
          rd_addr <= '0;
          if (pass_cnt == drain_passes - 1'b1) begin
            pass_cnt <= '0;
            dstate   <= D_IDLE;
          end else pass_cnt <= pass_cnt + 1'b1;
        end else rd_addr <= rd_addr + 1'b1;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    wc_bank_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk   (clk),
      .we    (accept && (fill_sel == 1'(b))),
      .waddr (wr_cnt[AW-1:0]),
      .wdata (s_data),
      .re    (rd_issue && (fill_sel != 1'(b))),
      .raddr (rd_addr[AW-1:0]),
      .rdata (bank_q[b])
    );
  end

  assign w_valid = rd_vld;
  assign w_last  = rd_last;
  assign w_data  = rd_vld ? bank_q[rd_bank] : '0;
  assign busy    = (fstate != F_IDLE) || (dstate != D_IDLE);
endmodule
